// File: rtl/treasure_result_reporter.sv
// treasure_result_reporter: classifies per-frame vote counts, debounces the code,
// drives status LEDs and sends each newly stable code over a paced serial line.
module treasure_result_reporter #(
  parameter int CNT_W         = 16,
  parameter int MIN_VOTES     = 6,
  parameter int MIN_HALF      = 3,
  parameter int STABLE_FRAMES = 3,
  parameter int BIT_CYCLES    = 2500
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             FRAME_DONE,
  input  logic [CNT_W-1:0] NUM_NEG,
  input  logic [CNT_W-1:0] NUM_POS,
  input  logic [CNT_W-1:0] NUM_STRAIGHT,
  input  logic [CNT_W-1:0] NUM_RED,
  input  logic [CNT_W-1:0] NUM_BLUE,
  input  logic             TX_READY,
  output logic             TX_LINE,
  output logic             TX_BUSY,
  output logic [2:0]       RESULT,
  output logic             RESULT_VALID,
  output logic [7:0]       LED
);
  localparam int BW = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] MV = CNT_W'(MIN_VOTES);
  localparam logic [CNT_W-1:0] MH = CNT_W'(MIN_HALF);
  localparam logic [3:0] SF = 4'(STABLE_FRAMES);
  localparam logic [BW-1:0] BL = BW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic fd_prev, fd_rise, red, blue, accept, launch, pending, bit_done, line_n;
  logic [1:0] shape, idx, idx_n;
  logic [2:0] code, candidate, pend_code, shift, shift_n;
  logic [3:0] count, next_count;
  logic [BW-1:0] bit_cnt, bit_n;

  // Counts are only compared, never added, so all-ones inputs cannot wrap.
  always_comb begin
    fd_rise = FRAME_DONE & ~fd_prev;
    red = NUM_RED >= MV;
    blue = ~red & (NUM_BLUE >= MV);
    shape = (NUM_NEG >= MH && NUM_POS >= MH) ? 2'b11 :
            (NUM_NEG >= MV) ? 2'b01 :
            (NUM_STRAIGHT >= MV) ? 2'b10 : 2'b00;
    code = ((red | blue) && shape != 2'b00) ? {blue, shape} : 3'b000;
    next_count = (code == candidate) ? ((count >= SF) ? SF : count + 4'd1) : 4'd1;
    accept = fd_rise && next_count == SF && code != RESULT;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fd_prev <= 1'b0;
      candidate <= 3'b000;
      count <= 4'd0;
      RESULT <= 3'b000;
      RESULT_VALID <= 1'b0;
      pending <= 1'b0;
      pend_code <= 3'b000;
    end else begin
      fd_prev <= FRAME_DONE;
      if (fd_rise) begin
        candidate <= code;
        count <= next_count;
      end
      if (accept) begin
        RESULT <= code;
        pend_code <= code;
        RESULT_VALID <= RESULT_VALID | (code != 3'b000);
      end
      pending <= accept | (pending & ~launch);
    end
  end

  // Line value is computed from the next state so TX_LINE is registered alongside it.
  always_comb begin
    state_n = state;
    idx_n = idx;
    launch = 1'b0;
    bit_done = bit_cnt == BL;
    bit_n = (state == IDLE || bit_done) ? '0 : bit_cnt + 1'b1;
    case (state)
      IDLE: if (pending && TX_READY) begin
        launch = 1'b1;
        state_n = START;
        idx_n = 2'd0;
      end
      START: if (bit_done) state_n = DATA;
      DATA: if (bit_done) begin
        idx_n = idx + 2'd1;
        if (idx == 2'd2) state_n = PARITY;
      end
      PARITY: if (bit_done) state_n = STOP;
      STOP: if (bit_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    shift_n = launch ? pend_code : shift;
    line_n = (state_n == START) ? 1'b0 :
             (state_n == DATA) ? shift_n[idx_n] :
             (state_n == PARITY) ? ^shift_n : 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= IDLE;
      bit_cnt <= '0;
      idx <= 2'd0;
      shift <= 3'b000;
      TX_LINE <= 1'b1;
      TX_BUSY <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      idx <= idx_n;
      shift <= shift_n;
      TX_LINE <= line_n;
      TX_BUSY <= state_n != IDLE;
    end
  end

  assign LED = {RESULT_VALID, pending, TX_BUSY, 2'b00, RESULT};
endmodule

// File: tb/tb_treasure_result_reporter.sv
// tb_treasure_result_reporter: table-driven, directed and randomized checks of the
// classifier, debounce, LEDs and serial framing against a frame-history model.
module tb_treasure_result_reporter;
  localparam int BC = 4;
  localparam int SF = 3;

  logic CLK = 1'b0, RESET_N = 1'b0, FRAME_DONE = 1'b0, TX_READY = 1'b0;
  logic [15:0] NUM_NEG = '0, NUM_POS = '0, NUM_STRAIGHT = '0, NUM_RED = '0, NUM_BLUE = '0;
  logic TX_LINE, TX_BUSY, RESULT_VALID;
  logic [2:0] RESULT;
  logic [7:0] LED;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [15:0] neg, pos, str, red, blue;
    logic [2:0] code;
  } vec_t;
  vec_t tbl[10];
  logic [2:0] hist[$];
  logic [2:0] m_res = 3'b000;
  logic m_valid = 1'b0, m_pend = 1'b0;

  always #5 CLK = ~CLK;

  treasure_result_reporter #(.CNT_W(16), .MIN_VOTES(6), .MIN_HALF(3),
    .STABLE_FRAMES(SF), .BIT_CYCLES(BC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FRAME_DONE(FRAME_DONE),
    .NUM_NEG(NUM_NEG), .NUM_POS(NUM_POS), .NUM_STRAIGHT(NUM_STRAIGHT),
    .NUM_RED(NUM_RED), .NUM_BLUE(NUM_BLUE), .TX_READY(TX_READY),
    .TX_LINE(TX_LINE), .TX_BUSY(TX_BUSY), .RESULT(RESULT),
    .RESULT_VALID(RESULT_VALID), .LED(LED));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] classify(input vec_t v);
    logic is_red, is_blue;
    logic [1:0] sh;
    is_red = v.red >= 16'd6;
    is_blue = !is_red && v.blue >= 16'd6;
    sh = (v.neg >= 16'd3 && v.pos >= 16'd3) ? 2'd3 : (v.neg >= 16'd6) ? 2'd1 :
         (v.str >= 16'd6) ? 2'd2 : 2'd0;
    return (!(is_red || is_blue) || sh == 2'd0) ? 3'b000 : {is_blue, sh};
  endfunction

  // Expected line samples: start, 3 data bits LSB first, even parity, stop.
  function automatic logic [23:0] wave(input logic [2:0] c);
    logic [5:0] b;
    logic [23:0] w;
    b = {1'b1, ^c, c[2], c[1], c[0], 1'b0};
    w = '0;
    for (int i = 0; i < 24; i++) w = {w[22:0], b[i / BC]};
    return w;
  endfunction

  task automatic model_clear();
    hist.delete();
    m_res = 3'b000;
    m_valid = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    FRAME_DONE = 1'b0;
    TX_READY = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    model_clear();
  endtask

  task automatic set_counts(input vec_t v);
    NUM_NEG = v.neg;
    NUM_POS = v.pos;
    NUM_STRAIGHT = v.str;
    NUM_RED = v.red;
    NUM_BLUE = v.blue;
  endtask

  task automatic run_frame(input vec_t v, input logic rdy);
    logic [2:0] c;
    logic acc;
    logic [23:0] lv, bv;
    set_counts(v);
    TX_READY = rdy;
    FRAME_DONE = 1'b1;
    tick();
    c = classify(v);
    hist.push_back(c);
    if (hist.size() > SF) void'(hist.pop_front());
    acc = hist.size() == SF && c != m_res;
    foreach (hist[k]) if (hist[k] != c) acc = 1'b0;
    if (acc) begin
      m_res = c;
      if (c != 3'b000) m_valid = 1'b1;
    end
    chk("result", 32'(RESULT), 32'(m_res));
    chk("valid", 32'(RESULT_VALID), 32'(m_valid));
    chk("led", 32'(LED), 32'({m_valid, acc | m_pend, 1'b0, 2'b00, m_res}));
    lv = '0;
    bv = '0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 2) FRAME_DONE = 1'b0;
      lv = {lv[22:0], TX_LINE};
      bv = {bv[22:0], TX_BUSY};
    end
    tick();
    chk("tx_line", 32'(lv), 32'((acc && rdy) ? wave(c) : 24'hffffff));
    chk("tx_busy", 32'(bv), 32'((acc && rdy) ? 24'hffffff : 24'h000000));
    chk("busy_end", 32'(TX_BUSY), 32'd0);
    m_pend = rdy ? 1'b0 : (acc | m_pend);
  endtask

  initial begin
    vec_t v, rs, rd, bt, bs, rt;
    logic [23:0] lv;
    logic any_busy, all_high;
    tbl[0] = '{16'd0, 16'd0, 16'd7, 16'd8, 16'd0, 3'b010};
    tbl[1] = '{16'd6, 16'd3, 16'd0, 16'd9, 16'd9, 3'b011};
    tbl[2] = '{16'd6, 16'd2, 16'd0, 16'd0, 16'd6, 3'b101};
    tbl[3] = '{16'd5, 16'd2, 16'd5, 16'd5, 16'd5, 3'b000};
    tbl[4] = '{16'd3, 16'd3, 16'd0, 16'd6, 16'd0, 3'b011};
    tbl[5] = '{16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hffff, 3'b011};
    tbl[6] = '{16'd0, 16'd0, 16'd6, 16'd5, 16'd6, 3'b110};
    tbl[7] = '{16'd6, 16'd0, 16'd0, 16'd5, 16'd5, 3'b000};
    tbl[8] = '{16'd6, 16'd0, 16'd6, 16'd0, 16'd7, 3'b101};
    tbl[9] = '{16'd3, 16'd3, 16'd9, 16'd0, 16'd6, 3'b111};
    rs = tbl[0];
    rd = '{16'd3, 16'd3, 16'd0, 16'd6, 16'd0, 3'b011};
    bt = '{16'd6, 16'd0, 16'd0, 16'd0, 16'd6, 3'b101};
    bs = '{16'd0, 16'd0, 16'd6, 16'd0, 16'd6, 3'b110};
    rt = '{16'd6, 16'd0, 16'd0, 16'd6, 16'd0, 3'b001};

    // Reset held with FRAME_DONE toggling and valid red-square counts.
    set_counts(rs);
    TX_READY = 1'b1;
    RESET_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      FRAME_DONE = ~FRAME_DONE;
      tick();
    end
    chk("rst_line", 32'(TX_LINE), 32'd1);
    chk("rst_busy", 32'(TX_BUSY), 32'd0);
    chk("rst_result", 32'(RESULT), 32'd0);
    chk("rst_led", 32'(LED), 32'd0);
    FRAME_DONE = 1'b0;
    RESET_N = 1'b1;
    model_clear();
    any_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      any_busy |= TX_BUSY;
    end
    chk("rst_no_tx", 32'(any_busy), 32'd0);

    // Classification table; each entry presented for a full debounce window.
    for (int k = 0; k < 10; k++) begin
      do_reset();
      for (int f = 0; f < SF; f++) run_frame(tbl[k], 1'b1);
      chk($sformatf("table_code[%0d]", k), 32'(RESULT), 32'(tbl[k].code));
    end

    // Debounce: a broken run of red-diamond must not be accepted.
    do_reset();
    run_frame(rd, 1'b1);
    run_frame(rd, 1'b1);
    run_frame(bt, 1'b1);
    run_frame(bt, 1'b1);
    chk("debounce_hold", 32'(RESULT), 32'd0);
    run_frame(bt, 1'b1);
    chk("debounce_accept", 32'(RESULT), 32'h5);

    // Flow control: the later acceptance overwrites the pending code.
    do_reset();
    for (int f = 0; f < SF; f++) run_frame(bs, 1'b0);
    for (int f = 0; f < SF; f++) run_frame(rt, 1'b0);
    chk("flow_led_pending", 32'(LED), 32'hc1);
    TX_READY = 1'b1;
    lv = '0;
    for (int i = 0; i < 24; i++) begin
      tick();
      lv = {lv[22:0], TX_LINE};
    end
    chk("flow_wave", 32'(lv), 32'(wave(3'b001)));
    tick();
    chk("flow_led_done", 32'(LED), 32'h81);

    // Reset during the DATA state aborts the frame for good.
    do_reset();
    run_frame(rs, 1'b1);
    run_frame(rs, 1'b1);
    set_counts(rs);
    TX_READY = 1'b1;
    FRAME_DONE = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) tick();
    chk("mid_busy", 32'(TX_BUSY), 32'd1);
    RESET_N = 1'b0;
    FRAME_DONE = 1'b0;
    tick();
    chk("mid_rst_line", 32'(TX_LINE), 32'd1);
    chk("mid_rst_busy", 32'(TX_BUSY), 32'd0);
    chk("mid_rst_led", 32'(LED), 32'd0);
    RESET_N = 1'b1;
    model_clear();
    any_busy = 1'b0;
    all_high = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      any_busy |= TX_BUSY;
      all_high &= TX_LINE;
    end
    chk("mid_no_resume_busy", 32'(any_busy), 32'd0);
    chk("mid_no_resume_line", 32'(all_high), 32'd1);

    // Randomized frames with repeats so the debounce window is often met.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      v.neg = ($urandom_range(0, 15) == 0) ? 16'hffff : 16'($urandom_range(0, 9));
      v.pos = 16'($urandom_range(0, 9));
      v.str = 16'($urandom_range(0, 9));
      v.red = ($urandom_range(0, 15) == 0) ? 16'hffff : 16'($urandom_range(0, 9));
      v.blue = 16'($urandom_range(0, 9));
      v.code = 3'b000;
      for (int r = 0, reps = int'($urandom_range(1, 4)); r < reps; r++) run_frame(v, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/treasure_result_reporter.md
Name: treasure_result_reporter

Overview:
- Downstream of the camera downsampler/edge tracker. Consumes its per-frame vote counts (negative-slope, positive-slope and straight edge rows; red and blue samples) at each frame boundary.
- Classifies treasure colour and shape, and debounces the result over consecutive frames.
- Drives the 8 LEDs and sends each newly stable result to the Arduino over a one-wire serial link paced by the Arduino's ready line.

Parameters:
- CNT_W, 16, width of each vote-count input.
- MIN_VOTES, 6, minimum count for a colour decision, triangle (neg) or square (straight).
- MIN_HALF, 3, minimum neg AND pos counts for a diamond.
- STABLE_FRAMES, 3, consecutive identical frame codes needed to accept a result (legal range 1..15).
- BIT_CYCLES, 2500, CLK cycles per serial bit (10 kbit/s at 25 MHz); minimum 2.

Ports:
- CLK  in  1  system clock (25 MHz PLL output).
- RESET_N  in  1  synchronous, active-low reset.
- FRAME_DONE  in  1  level; its rising edge marks the end of a frame. Counts are valid while it is high.
- NUM_NEG  in  CNT_W  negative-slope row count.
- NUM_POS  in  CNT_W  positive-slope row count.
- NUM_STRAIGHT  in  CNT_W  straight row count.
- NUM_RED  in  CNT_W  red sample count.
- NUM_BLUE  in  CNT_W  blue sample count.
- TX_READY  in  1  Arduino ready to receive; sampled only in IDLE.
- TX_LINE  out  1  serial line, idles high.
- TX_BUSY  out  1  high while a serial frame is in flight.
- RESULT  out  3  current accepted code.
- RESULT_VALID  out  1  high once any nonzero code has been accepted since reset.
- LED  out  8  status.

Behaviour:
- Reset (RESET_N low at a CLK edge): clears all state and takes priority over every other event, including mid-transmission.
  - Outputs: TX_LINE=1, TX_BUSY=0, RESULT=0, RESULT_VALID=0, LED=0.
  - Internal: candidate=0, count=0, pending=0, FSM=IDLE, fd_prev=0.
- Frame event: fd_rise = FRAME_DONE & ~fd_prev. fd_prev is registered every cycle. All counts are sampled on the fd_rise cycle.
- Classification (unsigned compares):
  - Colour: red if NUM_RED>=MIN_VOTES; else blue if NUM_BLUE>=MIN_VOTES; else none.
  - Shape, in priority order:
    - diamond(11) if NEG>=MIN_HALF and POS>=MIN_HALF;
    - else triangle(01) if NEG>=MIN_VOTES;
    - else square(10) if STRAIGHT>=MIN_VOTES;
    - else none(00).
  - Code = {colour==blue, shape}. Code is forced to 000 if colour is none or shape is none.
- Debounce, on the fd_rise edge:
  - next_count = (code==candidate) ? min(count+1, STABLE_FRAMES) : 1.
  - candidate<=code; count<=next_count.
  - If next_count==STABLE_FRAMES and code!=RESULT: RESULT<=code, pending<=1, pend_code<=code.
  - RESULT_VALID is set when the accepted code is nonzero and stays set until reset.
  - Code 000 is accepted and transmitted like any other code.
- Pending buffer: one deep, latest wins. A new acceptance while busy or not-ready overwrites pend_code.
- TX FSM states: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state lasts exactly BIT_CYCLES, timed by a bit counter.
  - IDLE: if pending & TX_READY, then on that edge: shift<=pend_code, pending<=0, enter START. Same-edge acceptance and launch: the launch uses the value pending held before the edge; the new code stays pending.
  - START: TX_LINE=0.
  - DATA: 3 bits, LSB first, then go to PARITY.
  - PARITY: TX_LINE = XOR of the 3 data bits (even parity).
  - STOP: TX_LINE=1, then return to IDLE. TX_READY is not re-sampled until IDLE.
  - Total frame length = 6*BIT_CYCLES.
  - TX_LINE and TX_BUSY are registered. TX_BUSY=1 in every state except IDLE.
  - Changes to TX_READY mid-frame are ignored.
  - Latency: TX_LINE falls at the edge after the IDLE launch condition is sampled.
- LED = {RESULT_VALID, pending, TX_BUSY, 2'b00, RESULT}.
- Classification and debounce keep running during transmission.
- FRAME_DONE held high for many cycles counts as one event.
- Counts at all-ones must not wrap (no arithmetic on the inputs; compares only).

Test Plan:
Bench settings: BIT_CYCLES=4, STABLE_FRAMES=3.
1. Reset: hold RESET_N=0 for 5 cycles with FRAME_DONE toggling -> TX_LINE=1, RESULT=0, LED=0, no transmission.
2. Red square, TX_READY=1: three frames with RED=8, STRAIGHT=7, others 0 -> RESULT=010 after the third fd_rise, RESULT_VALID=1. TX_LINE carries 0,0,1,0,1,1 (start, LSB-first 010, parity 1, stop), each bit held 4 cycles. TX_BUSY high for 24 cycles.
3. Debounce: frame codes red-diamond, red-diamond, blue-triangle, blue-triangle, blue-triangle -> RESULT changes only at frame 5, to 101. Exactly one transmission.
4. Priority: NEG=6, POS=3, RED=9, BLUE=9 -> code 011 (diamond beats triangle, red beats blue).
5. Flow control: TX_READY=0 while blue-square (110) and then red-triangle (001) are accepted; then raise TX_READY -> only 001 is sent (start 0, bits 1,0,0, parity 1, stop 1).
6. Reset mid-frame: assert RESET_N=0 during the DATA state -> next edge TX_LINE=1, TX_BUSY=0, pending=0. No resumption after release.
